rf_write_arbiter: RTL

//  Shares the single write port (we3/wa3/wd3) of the 32x32 register file

---
 rtl/rf_write_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port (we3/wa3/wd3) between
// pipeline writeback (primary, strict priority) and a long-latency unit
// (secondary). Secondary writes are queued in an in-order FIFO and drained
// whenever the primary leaves the port idle. Port outputs are registered.
// Optional feature: define RF_ARB_FAIR_EN to add a wait counter and a STARVE
// state that stalls the pipeline for one cycle so the FIFO head is written
// after MAX_WAIT cycles of waiting. Without it, stall is tied to 0.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_we,
  input  logic [4:0]               p_wa,
  input  logic [31:0]              p_wd,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_wa,
  input  logic [31:0]              s_wd,
  output logic                     stall,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [31:0]              wd3,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_write_arbiter: DEPTH must be a power of 2 and >= 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("rf_write_arbiter: MAX_WAIT must be >= 1");
  end

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;

  logic push, push_keep, pop, empty, p_req, grant_p, grant_s;

  assign empty      = (count_q == '0);
  assign s_ready    = (count_q != CW'(DEPTH));
  assign push       = s_valid & s_ready;
  // Writes to r0 are architecturally void, so they are accepted but never stored.
  assign push_keep  = push & (s_wa != 5'd0);
  assign p_req      = p_we & (p_wa != 5'd0);
  assign pop        = grant_s;

`ifdef RF_ARB_FAIR_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, STARVE} state_t;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;

  // Grant selection and starvation tracking; STARVE forces the head through.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    grant_p = 1'b0;
    grant_s = 1'b0;
    if (state_q == STARVE) begin
      grant_s = !empty;
      state_d = NORMAL;
      wait_d  = '0;
    end else begin
      if (p_req)       grant_p = 1'b1;
      else if (!empty) grant_s = 1'b1;
      if (empty || grant_s) begin
        wait_d = '0;
      end else begin
        wait_d = wait_q + 1'b1;
        if (wait_d == WW'(MAX_WAIT)) state_d = STARVE;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign stall = (state_q == STARVE);
`else
  // Grant selection: primary always wins, the FIFO head takes idle cycles.
  always_comb begin
    grant_p = 1'b0;
    grant_s = 1'b0;
    if (p_req)       grant_p = 1'b1;
    else if (!empty) grant_s = 1'b1;
  end

  assign stall = 1'b0;
`endif

  // FIFO bookkeeping and next port values; wa3/wd3 hold when nothing is granted.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_keep) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push_keep) - CW'(pop);
    we3_d   = grant_p | grant_s;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    if (grant_p) begin
      wa3_d = p_wa;
      wd3_d = p_wd;
    end else if (grant_s) begin
      wa3_d = fifo_wa[rd_ptr_q];
      wd3_d = fifo_wd[rd_ptr_q];
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (push_keep) begin
      fifo_wa[wr_ptr_q] <= s_wa;
      fifo_wd[wr_ptr_q] <= s_wd;
    end
  end

  // Pointers, occupancy and registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= 5'd0;
      wd3_q    <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign we3        = we3_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;
  assign fifo_count = count_q;

endmodule
